// File: rtl/sum_arbiter.sv
// Shared WIDTH-bit adder with a round-robin arbiter over CHANNELS requesters,
// per-channel accumulators and a DEPTH-stage stallable result pipeline.
// Define SUM_SAT_EN to saturate results on carry instead of wrapping.
module sum_arbiter #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 2,
  localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       req_valid,
  output logic [CHANNELS-1:0]       req_ready,
  input  logic [CHANNELS*WIDTH-1:0] req_a,
  input  logic [CHANNELS*WIDTH-1:0] req_b,
  input  logic [CHANNELS-1:0]       req_acc,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [CW-1:0]             rsp_chan,
  output logic [WIDTH-1:0]          rsp_sum,
  output logic                      rsp_ovf
);

  logic [DEPTH-1:0] stg_valid;
  logic [DEPTH-1:0] stg_ovf;
  logic [CW-1:0]    stg_chan [DEPTH];
  logic [WIDTH-1:0] stg_sum  [DEPTH];

  logic [WIDTH-1:0] acc   [CHANNELS];
  logic [WIDTH-1:0] a_arr [CHANNELS];
  logic [WIDTH-1:0] b_arr [CHANNELS];

  logic [CW-1:0]    ptr;
  logic [CW-1:0]    next_ptr;
  logic [CW-1:0]    grant_idx;
  logic             grant_any;
  logic             advance;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH:0]   full;
  logic [WIDTH-1:0] result;

  assign advance = !stg_valid[DEPTH-1] || rsp_ready;

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      a_arr[c] = req_a[c*WIDTH +: WIDTH];
      b_arr[c] = req_b[c*WIDTH +: WIDTH];
    end
  end

  // First valid channel at or after the pointer wins; nothing is granted while stalled.
  always_comb begin
    logic [CW-1:0] idx;
    idx       = '0;
    req_ready = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    if (advance) begin
      for (int i = 0; i < CHANNELS; i++) begin
        idx = CW'((int'(ptr) + i) % CHANNELS);
        if (!grant_any && req_valid[idx]) begin
          grant_any = 1'b1;
          grant_idx = idx;
        end
      end
    end
    req_ready[grant_idx] = grant_any;
  end

  always_comb begin
    next_ptr = (grant_idx == CW'(CHANNELS - 1)) ? '0 : grant_idx + 1'b1;
    op_a     = a_arr[grant_idx];
    op_b     = req_acc[grant_idx] ? acc[grant_idx] : b_arr[grant_idx];
    full     = {1'b0, op_a} + {1'b0, op_b};
`ifdef SUM_SAT_EN
    result   = full[WIDTH] ? '1 : full[WIDTH-1:0];
`else
    result   = full[WIDTH-1:0];
`endif
  end

  // Accumulator writes land at the accept edge so back-to-back accumulates chain.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr <= '0;
      for (int c = 0; c < CHANNELS; c++) acc[c] <= '0;
    end else if (grant_any) begin
      ptr <= next_ptr;
      if (req_acc[grant_idx]) acc[grant_idx] <= result;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stg_valid <= '0;
      stg_ovf   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        stg_chan[i] <= '0;
        stg_sum[i]  <= '0;
      end
    end else if (advance) begin
      stg_valid[0] <= grant_any;
      stg_ovf[0]   <= full[WIDTH];
      stg_chan[0]  <= grant_idx;
      stg_sum[0]   <= result;
      for (int i = 1; i < DEPTH; i++) begin
        stg_valid[i] <= stg_valid[i-1];
        stg_ovf[i]   <= stg_ovf[i-1];
        stg_chan[i]  <= stg_chan[i-1];
        stg_sum[i]   <= stg_sum[i-1];
      end
    end
  end

  assign rsp_valid = stg_valid[DEPTH-1];
  assign rsp_ovf   = stg_ovf[DEPTH-1];
  assign rsp_chan  = stg_chan[DEPTH-1];
  assign rsp_sum   = stg_sum[DEPTH-1];

endmodule

// File: tb/tb_sum_arbiter.sv
// Bench for sum_arbiter: queue-based reference model checked every cycle,
// plus directed vectors with hand-computed results.
module tb_sum_arbiter;

  localparam int WIDTH    = 8;
  localparam int CHANNELS = 2;
  localparam int DEPTH    = 2;
  localparam int CW       = 1;
`ifdef SUM_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic                      clock = 1'b0;
  logic                      reset = 1'b1;
  logic [CHANNELS-1:0]       req_valid = '0;
  logic [CHANNELS-1:0]       req_ready;
  logic [CHANNELS*WIDTH-1:0] req_a;
  logic [CHANNELS*WIDTH-1:0] req_b;
  logic [CHANNELS-1:0]       req_acc = '0;
  logic                      rsp_valid;
  logic                      rsp_ready = 1'b1;
  logic [CW-1:0]             rsp_chan;
  logic [WIDTH-1:0]          rsp_sum;
  logic                      rsp_ovf;

  int a_val [CHANNELS] = '{0, 0};
  int b_val [CHANNELS] = '{0, 0};

  assign req_a = {WIDTH'(a_val[1]), WIDTH'(a_val[0])};
  assign req_b = {WIDTH'(b_val[1]), WIDTH'(b_val[0])};

  sum_arbiter #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_acc(req_acc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_chan(rsp_chan), .rsp_sum(rsp_sum), .rsp_ovf(rsp_ovf)
  );

  always #5 clock = ~clock;

  typedef struct { bit v; int chan; int sum; bit ovf; } item_t;

  item_t m_pipe[$];
  int    m_acc [CHANNELS];
  int    m_ptr;
  int    n_acc;
  int    n_rsp;
  int    total = 0;
  int    bad   = 0;

  task automatic check_output(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_clear();
    item_t bubble;
    bubble = '{1'b0, 0, 0, 1'b0};
    m_pipe.delete();
    for (int i = 0; i < DEPTH; i++) m_pipe.push_back(bubble);
    for (int c = 0; c < CHANNELS; c++) m_acc[c] = 0;
    m_ptr = 0;
    n_acc = 0;
    n_rsp = 0;
  endfunction

  // Reference model: the pipeline is a queue of DEPTH slots, arithmetic in plain ints.
  always @(negedge clock) begin : compare
    item_t tail;
    item_t ent;
    bit    adv;
    bit    found;
    int    g;
    int    c;
    int    full;
    int    exp_ready;
    if (reset) begin
      model_clear();
      check_output("rsp_valid_in_reset", int'(rsp_valid), 0);
    end else begin
      tail = m_pipe[DEPTH-1];
      check_output("model_rsp_valid", int'(rsp_valid), int'(tail.v));
      if (tail.v) begin
        check_output("model_rsp_chan", int'(rsp_chan), tail.chan);
        check_output("model_rsp_sum", int'(rsp_sum), tail.sum);
        check_output("model_rsp_ovf", int'(rsp_ovf), int'(tail.ovf));
      end
      adv   = !tail.v || rsp_ready;
      found = 1'b0;
      g     = 0;
      if (adv) begin
        for (int i = 0; i < CHANNELS; i++) begin
          c = (m_ptr + i) % CHANNELS;
          if (!found && (((int'(req_valid) >> c) & 1) != 0)) begin
            found = 1'b1;
            g     = c;
          end
        end
      end
      exp_ready = found ? (1 << g) : 0;
      check_output("model_req_ready", int'(req_ready), exp_ready);
      if (rsp_valid && rsp_ready) n_rsp++;
      if ((req_valid & req_ready) != '0) n_acc++;
      ent = '{1'b0, 0, 0, 1'b0};
      if (found) begin
        if (((int'(req_acc) >> g) & 1) != 0) full = a_val[g] + m_acc[g];
        else                                 full = a_val[g] + b_val[g];
        ent.v    = 1'b1;
        ent.chan = g;
        ent.ovf  = (full >= (1 << WIDTH));
        if (!ent.ovf)  ent.sum = full;
        else if (SAT)  ent.sum = (1 << WIDTH) - 1;
        else           ent.sum = full - (1 << WIDTH);
        if (((int'(req_acc) >> g) & 1) != 0) m_acc[g] = ent.sum;
        m_ptr = (g + 1) % CHANNELS;
      end
      if (adv) begin
        m_pipe.push_front(ent);
        m_pipe.delete(DEPTH);
      end
    end
  end

  task automatic apply_stimulus(input logic [1:0] valid, input logic [1:0] acc,
                                input int a0, input int b0, input int a1, input int b1,
                                input logic rdy);
    req_valid = valid;
    req_acc   = acc;
    a_val[0]  = a0;
    b_val[0]  = b0;
    a_val[1]  = a1;
    b_val[1]  = b1;
    rsp_ready = rdy;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic reset_dut();
    @(posedge clock);
    #1;
    reset = 1'b1;
    apply_stimulus(2'b00, 2'b00, 0, 0, 0, 0, 1'b1);
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    // Reset state
    reset_dut();
    check_output("reset_rsp_valid", int'(rsp_valid), 0);
    check_output("reset_rsp_sum", int'(rsp_sum), 0);
    check_output("reset_rsp_chan", int'(rsp_chan), 0);
    check_output("reset_rsp_ovf", int'(rsp_ovf), 0);
    check_output("reset_idle_ready", int'(req_ready), 0);

    // Single op latency
    apply_stimulus(2'b01, 2'b00, 1, 2, 0, 0, 1'b1);
    #1 check_output("t1_grant_ch0", int'(req_ready), 1);
    tick();
    apply_stimulus(2'b00, 2'b00, 0, 0, 0, 0, 1'b1);
    check_output("t1_not_yet", int'(rsp_valid), 0);
    tick();
    check_output("t1_valid", int'(rsp_valid), 1);
    check_output("t1_chan", int'(rsp_chan), 0);
    check_output("t1_sum", int'(rsp_sum), 3);
    check_output("t1_ovf", int'(rsp_ovf), 0);
    tick();
    check_output("t1_done", int'(rsp_valid), 0);

    // Round-robin alternation
    reset_dut();
    apply_stimulus(2'b11, 2'b00, 10, 1, 20, 2, 1'b1);
    for (int i = 0; i < 8; i++) begin
      #1 check_output("rr_ready", int'(req_ready), (i % 2 == 0) ? 1 : 2);
      if (i >= 2) begin
        check_output("rr_valid", int'(rsp_valid), 1);
        check_output("rr_chan", int'(rsp_chan), i % 2);
        check_output("rr_sum", int'(rsp_sum), (i % 2 == 0) ? 11 : 22);
      end
      tick();
    end
    apply_stimulus(2'b00, 2'b00, 0, 0, 0, 0, 1'b1);
    repeat (DEPTH + 1) tick();

    // Accumulate chain on ch1, then ch0 normal ops leave acc0 untouched
    reset_dut();
    apply_stimulus(2'b10, 2'b10, 0, 0, 5, 0, 1'b1);
    tick();
    tick();
    check_output("acc_sum_5", int'(rsp_sum), 5);
    check_output("acc_chan_1", int'(rsp_chan), 1);
    tick();
    apply_stimulus(2'b00, 2'b00, 0, 0, 0, 0, 1'b1);
    check_output("acc_sum_10", int'(rsp_sum), 10);
    tick();
    check_output("acc_sum_15", int'(rsp_sum), 15);
    apply_stimulus(2'b01, 2'b00, 7, 8, 0, 0, 1'b1);
    tick();
    tick();
    apply_stimulus(2'b01, 2'b01, 1, 0, 0, 0, 1'b1);
    tick();
    apply_stimulus(2'b00, 2'b00, 0, 0, 0, 0, 1'b1);
    check_output("acc_ch0_normal", int'(rsp_sum), 15);
    tick();
    check_output("acc0_from_zero", int'(rsp_sum), 1);
    check_output("acc0_chan", int'(rsp_chan), 0);
    tick();

    // Overflow in normal and accumulate modes
    reset_dut();
    apply_stimulus(2'b01, 2'b00, 200, 100, 0, 0, 1'b1);
    tick();
    apply_stimulus(2'b00, 2'b00, 0, 0, 0, 0, 1'b1);
    tick();
    check_output("ovf_sum", int'(rsp_sum), SAT ? 255 : 44);
    check_output("ovf_flag", int'(rsp_ovf), 1);
    apply_stimulus(2'b10, 2'b10, 0, 0, 200, 0, 1'b1);
    tick();
    tick();
    apply_stimulus(2'b00, 2'b00, 0, 0, 0, 0, 1'b1);
    check_output("acc_ovf_first", int'(rsp_sum), 200);
    check_output("acc_ovf_first_flag", int'(rsp_ovf), 0);
    tick();
    check_output("acc_ovf_second", int'(rsp_sum), SAT ? 255 : 144);
    check_output("acc_ovf_second_flag", int'(rsp_ovf), 1);
    tick();

    // Stall with both channels requesting
    reset_dut();
    apply_stimulus(2'b11, 2'b00, 3, 4, 5, 6, 1'b0);
    #1 check_output("stall_fill_ch0", int'(req_ready), 1);
    tick();
    check_output("stall_fill_ch1", int'(req_ready), 2);
    tick();
    for (int i = 0; i < 4; i++) begin
      check_output("stall_ready_zero", int'(req_ready), 0);
      check_output("stall_valid", int'(rsp_valid), 1);
      check_output("stall_chan", int'(rsp_chan), 0);
      check_output("stall_sum", int'(rsp_sum), 7);
      tick();
    end
    rsp_ready = 1'b1;
    #1 check_output("stall_release_grant", int'(req_ready), 1);
    repeat (4) tick();
    apply_stimulus(2'b00, 2'b00, 0, 0, 0, 0, 1'b1);
    repeat (DEPTH + 2) tick();
    check_output("stall_conservation", n_rsp, n_acc);

    // Reset with results in flight
    reset_dut();
    apply_stimulus(2'b10, 2'b10, 0, 0, 4, 0, 1'b1);
    tick();
    tick();
    check_output("rst_inflight_sum", int'(rsp_sum), 4);
    #1 reset = 1'b1;
    #1 check_output("rst_valid_drops", int'(rsp_valid), 0);
    tick();
    tick();
    reset = 1'b0;
    check_output("rst_after_release", int'(rsp_valid), 0);
    tick();
    check_output("rst_no_stale", int'(rsp_valid), 0);
    tick();
    apply_stimulus(2'b00, 2'b00, 0, 0, 0, 0, 1'b1);
    check_output("rst_acc_restart_valid", int'(rsp_valid), 1);
    check_output("rst_acc_restart_sum", int'(rsp_sum), 4);
    repeat (DEPTH + 1) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
